drum_pattern_sequencer: RTL
===========================

Name: drum_pattern_sequencer

Overview:
- Records drum-pad strikes from the keyboard key-state storage as timestamped events, then replays them as one-cycle pad pulses.
- Sits between the PS/2 key-state storage and the drum sound/VGA note logic.
- Sequences the drums sub-states: start recording (spacebar), capture pads (F, G, ...), stop (Enter), play back.

Parameters:
NUM_PADS, 8, number of pad key inputs; bit i maps to pad i
DEPTH, 16, event store entries; must be a power of 2
TS_WIDTH, 16, timestamp width in ticks
TICK_DIV, 50000, CLOCK_50 cycles per timestamp tick (1 ms); must be >= DEPTH+2

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high reset
pad_keys  in  NUM_PADS  level key state per pad (1 = held)
rec_start  in  1  level; rising edge requests recording
play_start  in  1  level; rising edge requests playback
stop  in  1  level; rising edge ends record/playback
pad_strike  out  NUM_PADS  registered one-cycle strike pulses during playback
state  out  2  0=IDLE 1=ARMED 2=RECORD 3=PLAY
event_count  out  log2(DEPTH)+1  entries stored
overflow  out  1  sticky; set when an event was dropped on a full store
busy  out  1  high when state != IDLE

Behaviour:
- Reset (sync, active-high): state=IDLE, pad_strike=0, event_count=0, overflow=0, busy=0, timer=0, prescaler=0, edge-detect registers loaded with current inputs. Reset in any state aborts immediately with no further strikes.
- Edge detect: per-bit rising edge = input & ~previous-cycle input, on pad_keys, rec_start, play_start and stop.
- Tick: prescaler counts 0..TICK_DIV-1 and wraps. The wrap cycle increments timer. Prescaler and timer are cleared on entry to RECORD and PLAY.
- IDLE:
  - rec_start edge: event_count=0, overflow=0, go ARMED.
  - Otherwise play_start edge with event_count>0: go PLAY with rd=0.
  - play_start with event_count==0 is ignored.
  - If both edges occur in the same cycle, record wins.
- ARMED:
  - Timer held at 0.
  - First cycle with any pad edge: store {ts=0, mask=edges}, go RECORD.
  - stop edge: go IDLE with count=0.
- RECORD:
  - Any cycle with non-zero pad edges writes one entry {timer, edge mask}. Simultaneous pads share one entry.
  - Edges in different cycles of the same tick give separate entries with equal ts.
  - Full store (count==DEPTH) with a new edge: entry dropped, overflow=1, go IDLE.
  - stop edge: go IDLE. If a pad edge occurs in the same cycle, it is stored first.
  - Timer reaching all-ones: go IDLE. No timestamp wrap.
  - play_start and rec_start are ignored.
- PLAY:
  - Each cycle, if rd<count and timer==ts[rd]: rd++, and pad_strike=mask[rd] on the next cycle for exactly one cycle.
  - Equal-ts entries strike on consecutive cycles, in store order.
  - After the last entry's strike cycle: go IDLE (see Optional Feature).
  - stop edge: go IDLE. No strike is issued in the following cycle; a strike already registered this cycle still completes.
  - rec_start and play_start are ignored.
- The recorded store is retained across playbacks until the next rec_start edge or reset.
- event_count updates in the cycle after the write. busy is combinational from state.

Optional Feature:
- Macro: DRUM_LOOP_PLAYBACK_EN.
- Defined: after the last entry's strike, wait for the next tick wrap, then restart playback with rd=0, timer=0 and prescaler=0. Playback loops until a stop edge or reset.
- Undefined: return to IDLE after the last strike.
- All other behaviour is identical in both builds.

Test Plan:
- Params TICK_DIV=4, DEPTH=4. Pulse rec_start, F (pad0) edge, 3 ticks later G (pad1) edge, then stop -> state 0→1→2→0; event_count=2; entries {0,0x01},{3,0x02}; overflow=0.
- Pulse play_start after that recording -> pad_strike=0x01 one cycle after PLAY entry; pad_strike=0x02 one cycle after timer==3; then state=0 (loop off) or strikes repeat every 4 ticks until stop (loop on).
- Raise pads 0 and 2 in the same cycle during RECORD -> single entry with mask 0x05; pad_strike replays 0x05 in one cycle.
- Record 5 edges with DEPTH=4 -> event_count=4, overflow=1, state=IDLE after the 5th edge; playback emits exactly 4 strikes.
- play_start with event_count=0 -> state stays 0, pad_strike stays 0. Simultaneous rec_start and play_start -> state=ARMED.
- Assert reset mid-PLAY and stop mid-RECORD -> all outputs 0 / state IDLE on the next cycle; no spurious pad_strike afterwards.

Source files
------------

// File: rtl/drum_pattern_sequencer.sv
// drum_pattern_sequencer: records pad strikes as {timestamp, pad mask} events
// and replays them as one-cycle pad_strike pulses.
// Optional build macro: DRUM_LOOP_PLAYBACK_EN (playback loops until stop/reset).
module drum_pattern_sequencer #(
  parameter int NUM_PADS = 8,
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 16,
  parameter int TICK_DIV = 50000
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic [NUM_PADS-1:0]      pad_keys,
  input  logic                     rec_start,
  input  logic                     play_start,
  input  logic                     stop,
  output logic [NUM_PADS-1:0]      pad_strike,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   event_count,
  output logic                     overflow,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_RECORD = 2'd2, S_PLAY = 2'd3} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [TS_WIDTH-1:0]   timer_q, timer_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         rd_q, rd_d;
  logic                  ovf_q, ovf_d;
  logic [NUM_PADS-1:0]   strike_q, strike_d;
  logic [NUM_PADS-1:0]   pad_prev_q;
  logic                  rec_prev_q, play_prev_q, stop_prev_q;

  logic [TS_WIDTH-1:0]   ts_mem   [DEPTH];
  logic [NUM_PADS-1:0]   mask_mem [DEPTH];
  logic                  wr_en;
  logic [AW-1:0]         wr_idx;
  logic [TS_WIDTH-1:0]   wr_ts;

  logic [NUM_PADS-1:0]   pad_edge;
  logic                  any_pad, rec_edge, play_edge, stop_edge, tick_wrap;
  logic [AW-1:0]         rd_idx;

  assign pad_edge  = pad_keys & ~pad_prev_q;
  assign any_pad   = |pad_edge;
  assign rec_edge  = rec_start & ~rec_prev_q;
  assign play_edge = play_start & ~play_prev_q;
  assign stop_edge = stop & ~stop_prev_q;
  assign tick_wrap = (presc_q == PW'(TICK_DIV - 1));
  assign rd_idx    = rd_q[AW-1:0];

  // Next-state, tick counting, store writes and playback strike selection
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_d     = rd_q;
    ovf_d    = ovf_q;
    strike_d = '0;
    wr_en    = 1'b0;
    wr_idx   = count_q[AW-1:0];
    wr_ts    = timer_q;
    // prescaler/timer run freely; IDLE and ARMED override them to zero so the
    // first RECORD/PLAY cycle always starts at tick 0
    if (tick_wrap) begin
      presc_d = '0;
      timer_d = timer_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
      timer_d = timer_q;
    end
    unique case (state_q)
      S_IDLE: begin
        presc_d = '0;
        timer_d = '0;
        if (rec_edge) begin
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = S_ARMED;
        end else if (play_edge && count_q != '0) begin
          rd_d    = '0;
          state_d = S_PLAY;
        end
      end
      S_ARMED: begin
        presc_d = '0;
        timer_d = '0;
        if (stop_edge) begin
          count_d = '0;
          state_d = S_IDLE;
        end else if (any_pad) begin
          wr_en   = 1'b1;
          wr_idx  = '0;
          wr_ts   = '0;
          count_d = CW'(1);
          state_d = S_RECORD;
        end
      end
      S_RECORD: begin
        if (any_pad) begin
          if (count_q == CW'(DEPTH)) begin
            ovf_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            wr_en   = 1'b1;
            count_d = count_q + 1'b1;
          end
        end
        // timestamps never wrap: a saturated timer ends the take
        if (stop_edge || (&timer_q)) state_d = S_IDLE;
      end
      S_PLAY: begin
        if (stop_edge) begin
          state_d = S_IDLE;
        end else if (rd_q == count_q) begin
`ifdef DRUM_LOOP_PLAYBACK_EN
          if (tick_wrap) begin
            rd_d    = '0;
            presc_d = '0;
            timer_d = '0;
          end
`else
          state_d = S_IDLE;
`endif
        end else if (timer_q == ts_mem[rd_idx]) begin
          rd_d     = rd_q + 1'b1;
          strike_d = mask_mem[rd_idx];
        end
      end
    endcase
  end

  // Control state registers; edge detectors reload current inputs on reset
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      timer_q     <= '0;
      count_q     <= '0;
      rd_q        <= '0;
      ovf_q       <= 1'b0;
      strike_q    <= '0;
      pad_prev_q  <= pad_keys;
      rec_prev_q  <= rec_start;
      play_prev_q <= play_start;
      stop_prev_q <= stop;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
      rd_q        <= rd_d;
      ovf_q       <= ovf_d;
      strike_q    <= strike_d;
      pad_prev_q  <= pad_keys;
      rec_prev_q  <= rec_start;
      play_prev_q <= play_start;
      stop_prev_q <= stop;
    end
  end

  // Event store: no reset, contents survive until overwritten by a new take
  always_ff @(posedge CLOCK_50) begin
    if (wr_en && !reset) begin
      ts_mem[wr_idx]   <= wr_ts;
      mask_mem[wr_idx] <= pad_edge;
    end
  end

  assign pad_strike  = strike_q;
  assign state       = state_q;
  assign event_count = count_q;
  assign overflow    = ovf_q;
  assign busy        = (state_q != S_IDLE);
endmodule
